// File: rtl/cycle_sequencer.sv
// cycle_sequencer: multicycle control sequencer for the single-clock processor.
// Steps each instruction through FETCH/DECODE/EXEC/(MWAIT)/(MEM)/WB. It drives
// one-cycle enable strobes instead of divided module clocks. It also handles
// mult/div ready/timeout, overflow-to-$30 status writes and a retired-instruction
// counter.
module cycle_sequencer #(
    parameter int MD_TIMEOUT = 32,
    parameter int CNT_W      = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic [4:0]       opcode,
    input  logic [4:0]       alu_op,
    input  logic             alu_overflow,
    input  logic             alu_rdy,
    output logic             ir_we,
    output logic             imem_en,
    output logic             rf_re,
    output logic             alu_start,
    output logic             dmem_en,
    output logic             dmem_we,
    output logic             rf_we,
    output logic             pc_en,
    output logic             rf_wsel_status,
    output logic [2:0]       status_code,
    output logic             busy,
    output logic             md_err,
    output logic [CNT_W-1:0] instr_count
);

    localparam int TW = $clog2(MD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MWAIT, S_MEM, S_WB
    } state_e;

    state_e           state_q, state_d;
    logic             ovf_q, ovf_d;
    logic [2:0]       code_q, code_d;
    logic             nowr_q, nowr_d;     // suppress rf_we after a mult/div timeout
    logic             md_err_q, md_err_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [CNT_W-1:0] icnt_q, icnt_d;

    // Instruction decode from the datapath IR (stable from DECODE onward).
    logic is_r, is_add, is_sub, is_mul, is_div, is_addi, is_sw, is_lw;
    logic is_md, is_addsub, is_mem, writes;
    logic [2:0] dec_code;

    // Classify the current instruction and pick its overflow status code.
    always_comb begin
        is_r      = (opcode == 5'b00000);
        is_add    = is_r && (alu_op == 5'b00000);
        is_sub    = is_r && (alu_op == 5'b00001);
        is_mul    = is_r && (alu_op == 5'b00110);
        is_div    = is_r && (alu_op == 5'b00111);
        is_addi   = (opcode == 5'b00101);
        is_sw     = (opcode == 5'b00111);
        is_lw     = (opcode == 5'b01000);
        is_md     = is_mul | is_div;
        is_addsub = is_add | is_sub | is_addi;
        is_mem    = is_sw | is_lw;
        writes    = is_addsub | is_md | is_lw;
        dec_code  = 3'd0;
        if (is_add)  dec_code = 3'd1;
        if (is_addi) dec_code = 3'd2;
        if (is_sub)  dec_code = 3'd3;
        if (is_mul)  dec_code = 3'd4;
        if (is_div)  dec_code = 3'd5;
    end

    // Next-state logic: stage sequencing, overflow capture, mult/div timeout.
    always_comb begin
        state_d  = state_q;
        ovf_d    = ovf_q;
        code_d   = code_q;
        nowr_d   = nowr_q;
        md_err_d = md_err_q;
        tmo_d    = tmo_q;
        icnt_d   = icnt_q;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                ovf_d   = 1'b0;
                nowr_d  = 1'b0;
                state_d = S_DECODE;
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                code_d = dec_code;
                // mul/div overflow arrives with alu_rdy, lw/sw never flag it
                ovf_d  = is_addsub & alu_overflow;
                if (is_md) begin
                    tmo_d   = '0;
                    state_d = S_MWAIT;
                end else if (is_mem) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MWAIT: begin
                if (alu_rdy) begin
                    ovf_d   = alu_overflow;
                    state_d = S_WB;
                end else if (tmo_q == TW'(MD_TIMEOUT - 1)) begin
                    md_err_d = 1'b1;
                    nowr_d   = 1'b1;
                    state_d  = S_WB;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_MEM: begin
                if (is_sw) begin
                    icnt_d  = icnt_q + CNT_W'(1);
                    state_d = run ? S_FETCH : S_IDLE;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                icnt_d  = icnt_q + CNT_W'(1);
                state_d = run ? S_FETCH : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and bookkeeping registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            ovf_q    <= 1'b0;
            code_q   <= 3'd0;
            nowr_q   <= 1'b0;
            md_err_q <= 1'b0;
            tmo_q    <= '0;
            icnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            ovf_q    <= ovf_d;
            code_q   <= code_d;
            nowr_q   <= nowr_d;
            md_err_q <= md_err_d;
            tmo_q    <= tmo_d;
            icnt_q   <= icnt_d;
        end
    end

    // Moore strobe decode of the registered state.
    always_comb begin
        ir_we          = 1'b0;
        imem_en        = 1'b0;
        rf_re          = 1'b0;
        alu_start      = 1'b0;
        dmem_en        = 1'b0;
        dmem_we        = 1'b0;
        rf_we          = 1'b0;
        pc_en          = 1'b0;
        rf_wsel_status = 1'b0;
        status_code    = 3'd0;
        case (state_q)
            S_FETCH: begin
                imem_en = 1'b1;
                ir_we   = 1'b1;
            end
            S_DECODE: rf_re     = 1'b1;
            S_EXEC:   alu_start = 1'b1;
            S_MEM: begin
                dmem_en = 1'b1;
                dmem_we = is_sw;
                pc_en   = is_sw;
            end
            S_WB: begin
                pc_en          = 1'b1;
                rf_we          = writes & ~nowr_q;
                rf_wsel_status = ovf_q;
                status_code    = ovf_q ? code_q : 3'd0;
            end
            default: ;
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign md_err      = md_err_q;
    assign instr_count = icnt_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Scoreboard bench for cycle_sequencer: per-cycle expected strobe vectors are
// queued with the stimulus for that cycle, then popped and compared each cycle.
module tb_cycle_sequencer;
    localparam int MDT = 32;
    localparam int CW  = 4;

    logic clock = 1'b0, reset = 1'b0, run = 1'b0;
    logic [4:0] opcode = 5'd0, alu_op = 5'd0;
    logic alu_overflow = 1'b0, alu_rdy = 1'b0;
    logic ir_we, imem_en, rf_re, alu_start, dmem_en, dmem_we, rf_we, pc_en;
    logic rf_wsel_status, busy, md_err;
    logic [2:0] status_code;
    logic [CW-1:0] instr_count;

    cycle_sequencer #(.MD_TIMEOUT(MDT), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .run(run), .opcode(opcode), .alu_op(alu_op),
        .alu_overflow(alu_overflow), .alu_rdy(alu_rdy), .ir_we(ir_we),
        .imem_en(imem_en), .rf_re(rf_re), .alu_start(alu_start), .dmem_en(dmem_en),
        .dmem_we(dmem_we), .rf_we(rf_we), .pc_en(pc_en),
        .rf_wsel_status(rf_wsel_status), .status_code(status_code), .busy(busy),
        .md_err(md_err), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    typedef enum {K_ADD, K_SUB, K_MUL, K_DIV, K_ADDI, K_SW, K_LW, K_NOP} kind_e;
    typedef struct {
        logic [13:0] exp;
        logic [4:0]  op;
        logic [4:0]  aop;
        logic        ovf;
        logic        rdy;
        logic        run;
    } cyc_t;

    cyc_t          sb_q[$];
    int            n_tests = 0, n_fail = 0;
    logic          md_exp = 1'b0;
    logic [CW-1:0] cnt_exp = '0;

    // {ir_we,imem_en,rf_re,alu_start,dmem_en,dmem_we,rf_we,pc_en,wsel,code[2:0],busy,md_err}
    function automatic logic [13:0] outv();
        return {ir_we, imem_en, rf_re, alu_start, dmem_en, dmem_we, rf_we, pc_en,
                rf_wsel_status, status_code, busy, md_err};
    endfunction

    function automatic logic [13:0] mk(logic [7:0] s, logic ws, logic [2:0] sc);
        return {s, ws, sc, 1'b1, md_exp};
    endfunction

    function automatic void push(logic [13:0] e, logic [4:0] op, logic [4:0] aop,
                                 logic ovf, logic rdy, logic rn);
        cyc_t c;
        c.exp = e; c.op = op; c.aop = aop; c.ovf = ovf; c.rdy = rdy; c.run = rn;
        sb_q.push_back(c);
    endfunction

    function automatic void push_idle(logic rn);
        push({13'b0, md_exp}, 5'd0, 5'd0, 1'b0, 1'b0, rn);
    endfunction

    // Reference model of one instruction, one queue entry per cycle from FETCH.
    function automatic void push_instr(kind_e k, logic ovf, int kw, logic tmo,
                                       logic early, logic rn);
        logic [4:0] op = 5'd0;
        logic [4:0] aop = 5'd0;
        logic [2:0] code = 3'd0;
        logic md, sw, mem, as, wr, oe;
        case (k)
            K_ADD:  code = 3'd1;
            K_SUB:  begin aop = 5'd1; code = 3'd3; end
            K_MUL:  begin aop = 5'd6; code = 3'd4; end
            K_DIV:  begin aop = 5'd7; code = 3'd5; end
            K_ADDI: begin op = 5'd5; code = 3'd2; end
            K_SW:   op = 5'd7;
            K_LW:   op = 5'd8;
            default: op = 5'd3;
        endcase
        md  = (k == K_MUL) || (k == K_DIV);
        sw  = (k == K_SW);
        mem = sw || (k == K_LW);
        as  = (k == K_ADD) || (k == K_SUB) || (k == K_ADDI);
        wr  = !(sw || k == K_NOP);
        oe  = md ? (ovf && !tmo) : (ovf && as);
        push(mk(8'b11000000, 1'b0, 3'd0), op, aop, 1'b0, 1'b0, rn);
        push(mk(8'b00100000, 1'b0, 3'd0), op, aop, 1'b0, 1'b0, rn);
        push(mk(8'b00010000, 1'b0, 3'd0), op, aop, ovf, early, rn);
        if (md) begin
            if (tmo) begin
                for (int i = 0; i < MDT; i++) push(mk(8'b0, 1'b0, 3'd0), op, aop, 1'b0, 1'b0, rn);
                md_exp = 1'b1;
            end else begin
                for (int i = 0; i < kw; i++) push(mk(8'b0, 1'b0, 3'd0), op, aop, 1'b0, 1'b0, rn);
                push(mk(8'b0, 1'b0, 3'd0), op, aop, ovf, 1'b1, rn);
            end
        end
        if (mem) push(mk({4'b0, 1'b1, sw, 1'b0, sw}, 1'b0, 3'd0), op, aop, ovf, 1'b0, rn);
        if (!sw) push(mk({6'b0, wr && !tmo, 1'b1}, oe, oe ? code : 3'd0), op, aop, 1'b0, 1'b0, rn);
        cnt_exp++;
    endfunction

    task automatic test_reset();
        reset = 1'b0; run = 1'b1;
        repeat (2) @(negedge clock);
        n_tests++;
        if (outv() !== 14'b0) begin n_fail++; $display("FAIL reset_outputs got=%b exp=%b", outv(), 14'b0); end
        n_tests++;
        if (instr_count !== '0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", instr_count); end
        run = 1'b0; reset = 1'b1;
        @(negedge clock);
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle busy=%b exp=0", busy); end
    endtask

    task automatic test_addi();
        cyc_t c;
        push_idle(1'b1); push_instr(K_ADDI, 1'b0, 0, 1'b0, 1'b0, 1'b0); push_idle(1'b0);
        while (sb_q.size() > 0) begin
            @(negedge clock); c = sb_q.pop_front(); n_tests++;
            if (outv() !== c.exp) begin n_fail++; $display("FAIL addi_cycle got=%b exp=%b", outv(), c.exp); end
            run = c.run; opcode = c.op; alu_op = c.aop; alu_overflow = c.ovf; alu_rdy = c.rdy;
        end
        n_tests++;
        if (instr_count !== cnt_exp) begin n_fail++; $display("FAIL addi_count got=%0d exp=%0d", instr_count, cnt_exp); end
    endtask

    task automatic test_overflow();
        cyc_t c;
        push_idle(1'b1);
        push_instr(K_ADD, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        push_instr(K_SUB, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        push_instr(K_ADDI, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        push_instr(K_ADD, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        push_instr(K_LW, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        push_instr(K_NOP, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        push_idle(1'b0);
        while (sb_q.size() > 0) begin
            @(negedge clock); c = sb_q.pop_front(); n_tests++;
            if (outv() !== c.exp) begin n_fail++; $display("FAIL ovf_cycle got=%b exp=%b", outv(), c.exp); end
            run = c.run; opcode = c.op; alu_op = c.aop; alu_overflow = c.ovf; alu_rdy = c.rdy;
        end
        n_tests++;
        if (instr_count !== cnt_exp) begin n_fail++; $display("FAIL ovf_count got=%0d exp=%0d", instr_count, cnt_exp); end
    endtask

    task automatic test_sw_lw();
        cyc_t c;
        push_idle(1'b1);
        push_instr(K_SW, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        push_instr(K_LW, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        push_instr(K_SW, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        push_idle(1'b0);
        while (sb_q.size() > 0) begin
            @(negedge clock); c = sb_q.pop_front(); n_tests++;
            if (outv() !== c.exp) begin n_fail++; $display("FAIL swlw_cycle got=%b exp=%b", outv(), c.exp); end
            run = c.run; opcode = c.op; alu_op = c.aop; alu_overflow = c.ovf; alu_rdy = c.rdy;
        end
        n_tests++;
        if (instr_count !== cnt_exp) begin n_fail++; $display("FAIL swlw_count got=%0d exp=%0d", instr_count, cnt_exp); end
    endtask

    task automatic test_muldiv();
        cyc_t c;
        push_idle(1'b1);
        push_instr(K_MUL, 1'b0, 2, 1'b0, 1'b1, 1'b1);
        push_instr(K_DIV, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        push_instr(K_MUL, 1'b1, 1, 1'b0, 1'b1, 1'b0);
        push_idle(1'b0);
        while (sb_q.size() > 0) begin
            @(negedge clock); c = sb_q.pop_front(); n_tests++;
            if (outv() !== c.exp) begin n_fail++; $display("FAIL muldiv_cycle got=%b exp=%b", outv(), c.exp); end
            run = c.run; opcode = c.op; alu_op = c.aop; alu_overflow = c.ovf; alu_rdy = c.rdy;
        end
        n_tests++;
        if (instr_count !== cnt_exp) begin n_fail++; $display("FAIL muldiv_count got=%0d exp=%0d", instr_count, cnt_exp); end
    endtask

    task automatic test_div_timeout();
        cyc_t c;
        push_idle(1'b1);
        push_instr(K_DIV, 1'b1, 0, 1'b1, 1'b0, 1'b1);
        push_instr(K_ADDI, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        push_idle(1'b0);
        while (sb_q.size() > 0) begin
            @(negedge clock); c = sb_q.pop_front(); n_tests++;
            if (outv() !== c.exp) begin n_fail++; $display("FAIL timeout_cycle got=%b exp=%b", outv(), c.exp); end
            run = c.run; opcode = c.op; alu_op = c.aop; alu_overflow = c.ovf; alu_rdy = c.rdy;
        end
        n_tests++;
        if (md_err !== md_exp) begin n_fail++; $display("FAIL timeout_md_err got=%b exp=%b", md_err, md_exp); end
        n_tests++;
        if (instr_count !== cnt_exp) begin n_fail++; $display("FAIL timeout_count got=%0d exp=%0d", instr_count, cnt_exp); end
    endtask

    task automatic test_run_stop();
        cyc_t c;
        push_idle(1'b1);
        push_instr(K_ADDI, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        push_idle(1'b0); push_idle(1'b0);
        while (sb_q.size() > 0) begin
            @(negedge clock); c = sb_q.pop_front(); n_tests++;
            if (outv() !== c.exp) begin n_fail++; $display("FAIL runstop_cycle got=%b exp=%b", outv(), c.exp); end
            run = c.run; opcode = c.op; alu_op = c.aop; alu_overflow = c.ovf; alu_rdy = c.rdy;
        end
        n_tests++;
        if (instr_count !== cnt_exp) begin n_fail++; $display("FAIL runstop_count got=%0d exp=%0d", instr_count, cnt_exp); end
    endtask

    task automatic test_wrap();
        cyc_t c;
        int n;
        n = (cnt_exp == '0) ? (1 << CW) : ((1 << CW) - int'(cnt_exp));
        push_idle(1'b1);
        for (int i = 0; i < n; i++) push_instr(K_NOP, 1'b0, 0, 1'b0, 1'b0, (i == n - 1) ? 1'b0 : 1'b1);
        push_idle(1'b0);
        while (sb_q.size() > 0) begin
            @(negedge clock); c = sb_q.pop_front(); n_tests++;
            if (outv() !== c.exp) begin n_fail++; $display("FAIL wrap_cycle got=%b exp=%b", outv(), c.exp); end
            run = c.run; opcode = c.op; alu_op = c.aop; alu_overflow = c.ovf; alu_rdy = c.rdy;
        end
        n_tests++;
        if (instr_count !== cnt_exp) begin n_fail++; $display("FAIL wrap_count got=%0d exp=%0d", instr_count, cnt_exp); end
    endtask

    task automatic test_reset_mid();
        cyc_t c;
        push_idle(1'b1); push_instr(K_LW, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        // stop on the MEM cycle of lw (idle, F, D, E, M)
        for (int i = 0; i < 5; i++) begin
            @(negedge clock); c = sb_q.pop_front(); n_tests++;
            if (outv() !== c.exp) begin n_fail++; $display("FAIL rstmid_cycle got=%b exp=%b", outv(), c.exp); end
            run = c.run; opcode = c.op; alu_op = c.aop; alu_overflow = c.ovf; alu_rdy = c.rdy;
        end
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if (outv() !== 14'b0) begin n_fail++; $display("FAIL rstmid_outputs got=%b exp=%b", outv(), 14'b0); end
        n_tests++;
        if (instr_count !== '0) begin n_fail++; $display("FAIL rstmid_count got=%0d exp=0", instr_count); end
        sb_q.delete(); md_exp = 1'b0; cnt_exp = '0;
        run = 1'b0;
        @(negedge clock); reset = 1'b1;
        push_idle(1'b1); push_instr(K_ADD, 1'b0, 0, 1'b0, 1'b0, 1'b0); push_idle(1'b0);
        while (sb_q.size() > 0) begin
            @(negedge clock); c = sb_q.pop_front(); n_tests++;
            if (outv() !== c.exp) begin n_fail++; $display("FAIL rstmid_restart got=%b exp=%b", outv(), c.exp); end
            run = c.run; opcode = c.op; alu_op = c.aop; alu_overflow = c.ovf; alu_rdy = c.rdy;
        end
        n_tests++;
        if (instr_count !== cnt_exp) begin n_fail++; $display("FAIL rstmid_restart_count got=%0d exp=%0d", instr_count, cnt_exp); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_overflow();
        test_sw_lw();
        test_muldiv();
        test_div_timeout();
        test_run_stop();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
